dsp_fir_dec_ctrl: RTL and testbench
===================================

# dsp_fir_dec_ctrl

Sequencer and configuration controller in front of `dsp_fir_dec`. It accepts upstream samples with a valid/ready handshake and issues them to the filter no faster than one per `CLOCK_PER_SAMPLE` cycles, which is the filter's MAC budget. It holds a shadow coefficient bank that the host writes at any time. On request it drains the filter, streams the bank into the filter's coefficient port, then clears the filter's delay line before resuming.

## Interface
- `W_DIN`, 16, sample width.
- `W_COE`, 16, coefficient width.
- `N_COE`, 57, coefficient count. Constraint: `N_COE` ≤ 2^`W_ADDR`.
- `W_ADDR`, 6, coefficient address width.
- `CLOCK_PER_SAMPLE`, 30, minimum spacing between `f_din_val` pulses. Constraint: ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: gates sample acceptance.
- `s_data` in `W_DIN`: upstream sample.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: ready to accept an upstream sample.
- `f_din` out `W_DIN`: sample to the filter.
- `f_din_val` out 1: one-cycle sample strobe to the filter.
- `f_coe_we` out 1: filter coefficient write enable.
- `f_coe_addr` out `W_ADDR`: filter coefficient address.
- `f_coe_data` out `W_COE`: filter coefficient data.
- `f_clr` out 1: one-cycle pulse that clears the filter delay line and decimation phase.
- `cfg_we` in 1: shadow-bank write strobe.
- `cfg_addr` in `W_ADDR`: shadow-bank address.
- `cfg_data` in `W_COE`: shadow-bank data.
- `cfg_load` in 1: reload request pulse.
- `cfg_busy` out 1: high while a reload is in progress.
- `cfg_done` out 1: one-cycle pulse at reload completion.
- `cfg_err` out 1: sticky error flag.

## Operation
- **States:** RUN, DRAIN, LOAD, FLUSH. Reset state is RUN.
- **Slot counter `cnt`:**
  - On an accept (`s_valid && s_ready` at a clock edge), `cnt` loads `CLOCK_PER_SAMPLE-1`.
  - Otherwise `cnt` decrements while non-zero.
  - `s_ready = (state==RUN) && enable && (cnt==0)`.
- **Sample path:**
  - On accept, `f_din` registers `s_data` and `f_din_val` pulses high for 1 cycle.
  - `f_din` holds its value between accepts.
- **RUN → DRAIN:** on a `cfg_load` sampled in RUN.
  - If an accept occurs in the same cycle, the accept completes and DRAIN waits out the new slot.
  - `cfg_load` is ignored in any other state.
- **DRAIN → LOAD:** when `cnt==0`. If `cnt` is already 0, DRAIN lasts exactly 1 cycle.
- **LOAD:**
  - `f_coe_we` is high for exactly `N_COE` consecutive cycles.
  - `f_coe_addr` steps 0,1,…,`N_COE-1` ascending.
  - `f_coe_data = shadow[f_coe_addr]` in the same cycle.
  - A one-cycle read-prefetch cycle with `f_coe_we=0` precedes the first write.
- **FLUSH:** 1 cycle. `f_clr=1` and `cfg_done=1`. The next state is RUN.
- **Shadow bank:** `N_COE` × `W_COE` RAM, written on `cfg_we`.
  - `cfg_addr` ≥ `N_COE`: write ignored, `cfg_err` set.
  - `cfg_we` during LOAD: write ignored, `cfg_err` set.
  - Writes in RUN, DRAIN or FLUSH take effect.
  - Contents are not reset and are undefined until written.
- **`cfg_err`:** sticky; cleared on the cycle a `cfg_load` is accepted.
- **`cfg_busy`:** high in DRAIN, LOAD and FLUSH.
- **Reset values:** all outputs 0 (`s_ready`, `f_din`, `f_din_val`, `f_coe_we`, `f_coe_addr`, `f_coe_data`, `f_clr`, `cfg_busy`, `cfg_done`, `cfg_err`); `cnt`=0.
- **Reset asserted mid-LOAD:** the filter is left partially loaded. Software must reissue `cfg_load`.

## Timing
- **Sample path:**
  - Accept at edge t → `f_din`/`f_din_val` valid in cycle t+1.
  - Next earliest accept is at edge t+`CLOCK_PER_SAMPLE`.
  - `s_ready` is low for exactly `CLOCK_PER_SAMPLE-1` cycles after each accept.
- **`enable`:** combinational into `s_ready` only. Deasserting it does not cancel a pending slot countdown.
- **Reload sequence** (with `cnt==0` at request, `cfg_load` sampled at edge t):
  - t+1: DRAIN, `cfg_busy` rises.
  - t+2: first LOAD cycle, the prefetch.
  - t+3 … t+2+`N_COE`: write cycles.
  - t+3+`N_COE`: FLUSH, with `f_clr` and `cfg_done` pulsing.
  - t+4+`N_COE`: RUN, `cfg_busy` low, `s_ready` may be high.
- **`cfg_busy` duration:** `N_COE`+3 cycles when `cnt` is 0 at request; otherwise longer by the residual `cnt`.
- **After reset release:** `s_ready` may assert in the first cycle.

## Test plan
- **Pacing:** `s_valid` held high, `enable`=1, CPS=30 → `f_din_val` pulses every 30 cycles; `s_ready` high 1 cycle in 30; `f_din` equals the accepted `s_data` sequence 0x0040, 0x0080, ….
- **Backpressure/enable:** toggle `enable` low for 100 cycles → no accepts, `f_din_val` stays 0; first accept after re-enable only once `cnt==0`.
- **Reload idle:** write shadow[k]=k+1 for k=0..56, pulse `cfg_load` → `cfg_busy` high 60 cycles; 57 writes with addr 0..56 and data 1..57; `f_clr` and `cfg_done` coincide; `s_ready` low throughout.
- **Reload collision:** `cfg_load` in the same cycle as an accept → that sample still issued; DRAIN lasts 30 cycles; LOAD starts 30 cycles after the accept edge.
- **Errors:** `cfg_we` with addr 60, and `cfg_we` during LOAD → `cfg_err`=1 and shadow unchanged (verified by next reload data); next `cfg_load` clears `cfg_err`.
- **Reset mid-LOAD:** assert `rst_n`=0 at LOAD write 20 → all outputs 0 asynchronously; after release state is RUN and `cfg_busy`=0.

Source files
------------

// File: rtl/dsp_fir_dec_ctrl.sv
// Sequencer and configuration controller for dsp_fir_dec.
// Paces upstream samples into the filter at one per CLOCK_PER_SAMPLE cycles,
// keeps a host-writable shadow coefficient bank, and on request drains the
// filter, streams the bank into it and clears its delay line.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal operation, samples accepted when the slot is free
// ST_DRAIN | reload requested, waiting out the current sample slot
// ST_LOAD  | one read-prefetch cycle, then N_COE coefficient writes
// ST_FLUSH | single cycle: clear filter state, signal reload done
module dsp_fir_dec_ctrl #(
   parameter int W_DIN            = 16,
   parameter int W_COE            = 16,
   parameter int N_COE            = 57,
   parameter int W_ADDR           = 6,
   parameter int CLOCK_PER_SAMPLE = 30
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [W_DIN-1:0]  s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [W_DIN-1:0]  f_din,
   output logic              f_din_val,
   output logic              f_coe_we,
   output logic [W_ADDR-1:0] f_coe_addr,
   output logic [W_COE-1:0]  f_coe_data,
   output logic              f_clr,
   input  logic              cfg_we,
   input  logic [W_ADDR-1:0] cfg_addr,
   input  logic [W_COE-1:0]  cfg_data,
   input  logic              cfg_load,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_err
);

   localparam int W_CNT = $clog2(CLOCK_PER_SAMPLE);
   localparam logic [W_CNT-1:0]  CNT_RELOAD = W_CNT'(CLOCK_PER_SAMPLE - 1);
   // One extra bit so the pointer can reach N_COE even when N_COE == 2^W_ADDR.
   localparam logic [W_ADDR:0]   N_COE_W    = (W_ADDR + 1)'(N_COE);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [W_CNT-1:0]   cnt_q, cnt_d;
   logic [W_ADDR:0]    ptr_q, ptr_d;
   logic [W_DIN-1:0]   din_q;
   logic               din_val_q;
   logic               coe_we_q;
   logic [W_ADDR-1:0]  coe_addr_q;
   logic [W_COE-1:0]   coe_data_q;
   logic               err_q, err_d;
   logic               issue;
   logic               accept;
   logic               cfg_wr_bad;
   logic               cfg_wr_ok;

   logic [W_COE-1:0]   shadow_mem [N_COE];

   // rst_n gates ready so it reads 0 while reset is held, whatever enable does.
   assign s_ready    = rst_n && (state_q == ST_RUN) && enable && (cnt_q == '0);
   assign accept     = s_valid && s_ready;
   assign cfg_wr_bad = cfg_we && (({1'b0, cfg_addr} >= N_COE_W) || (state_q == ST_LOAD));
   assign cfg_wr_ok  = cfg_we && !cfg_wr_bad;

   // Next state and coefficient read pointer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      issue   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (cfg_load) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end
         ST_LOAD: begin
            // Reads issued here surface on the filter port one cycle later,
            // which makes the first LOAD cycle the prefetch.
            if (ptr_q == N_COE_W) begin
               state_d = ST_FLUSH;
            end else begin
               issue = 1'b1;
               ptr_d = ptr_q + 1'b1;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Slot down-counter and sticky error flag; a bad write wins over a clear.
   always_comb begin
      cnt_d = cnt_q;
      if (accept) cnt_d = CNT_RELOAD;
      else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      err_d = err_q;
      if ((state_q == ST_RUN) && cfg_load) err_d = 1'b0;
      if (cfg_wr_bad) err_d = 1'b1;
   end

   // Control, sample and coefficient output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         ptr_q      <= '0;
         din_q      <= '0;
         din_val_q  <= 1'b0;
         coe_we_q   <= 1'b0;
         coe_addr_q <= '0;
         coe_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         err_q     <= err_d;
         din_val_q <= accept;
         if (accept) din_q <= s_data;
         coe_we_q <= issue;
         if (issue) begin
            coe_addr_q <= ptr_q[W_ADDR-1:0];
            coe_data_q <= shadow_mem[ptr_q[W_ADDR-1:0]];
         end else begin
            coe_addr_q <= '0;
            coe_data_q <= '0;
         end
      end
   end

   // Shadow coefficient bank, deliberately not reset.
   always_ff @(posedge clk) begin
      if (cfg_wr_ok) shadow_mem[cfg_addr] <= cfg_data;
   end

   assign f_din      = din_q;
   assign f_din_val  = din_val_q;
   assign f_coe_we   = coe_we_q;
   assign f_coe_addr = coe_addr_q;
   assign f_coe_data = coe_data_q;
   assign f_clr      = (state_q == ST_FLUSH);
   assign cfg_done   = (state_q == ST_FLUSH);
   assign cfg_busy   = (state_q != ST_RUN);
   assign cfg_err    = err_q;

endmodule

// File: tb/tb_dsp_fir_dec_ctrl.sv
// Directed bench for dsp_fir_dec_ctrl: cycle vector table for pacing and
// enable behaviour, then hand sequences for reloads, errors and reset.
module tb_dsp_fir_dec_ctrl;

   localparam int N = 57;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [15:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] f_din;
   logic        f_din_val;
   logic        f_coe_we;
   logic [5:0]  f_coe_addr;
   logic [15:0] f_coe_data;
   logic        f_clr;
   logic        cfg_we;
   logic [5:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        cfg_load;
   logic        cfg_busy;
   logic        cfg_done;
   logic        cfg_err;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        en;
      logic        val;
      logic [15:0] data;
      logic        exp_rdy;
      logic        exp_fval;
      logic [15:0] exp_din;
   } vec_t;

   vec_t vecs[$];

   dsp_fir_dec_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .f_din      (f_din),
      .f_din_val  (f_din_val),
      .f_coe_we   (f_coe_we),
      .f_coe_addr (f_coe_addr),
      .f_coe_data (f_coe_data),
      .f_clr      (f_clr),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_load   (cfg_load),
      .cfg_busy   (cfg_busy),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " s_ready"},    s_ready,    0);
      chk({tag, " f_din"},      f_din,      0);
      chk({tag, " f_din_val"},  f_din_val,  0);
      chk({tag, " f_coe_we"},   f_coe_we,   0);
      chk({tag, " f_coe_addr"}, f_coe_addr, 0);
      chk({tag, " f_coe_data"}, f_coe_data, 0);
      chk({tag, " f_clr"},      f_clr,      0);
      chk({tag, " cfg_busy"},   cfg_busy,   0);
      chk({tag, " cfg_done"},   cfg_done,   0);
      chk({tag, " cfg_err"},    cfg_err,    0);
   endtask

   // Caller raises cfg_load before the edge; cycle i is the i-th after that edge.
   task automatic reload_check(input int drain, input bit inject,
                               input bit exp_val1, input logic [15:0] din1);
      int  last;
      bit  we_e;
      last = drain + N + 3;
      for (int i = 1; i <= last; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            cfg_load = 1'b0;
            s_valid  = 1'b0;
         end
         if (i == 11) cfg_we = 1'b0;
         we_e = (i >= drain + 2) && (i <= drain + 1 + N);
         chk("rl cfg_busy",  cfg_busy,  i < last);
         chk("rl f_coe_we",  f_coe_we,  we_e);
         chk("rl f_clr",     f_clr,     i == last - 1);
         chk("rl cfg_done",  cfg_done,  i == last - 1);
         chk("rl s_ready",   s_ready,   i == last);
         chk("rl cfg_err",   cfg_err,   inject && (i >= 11));
         chk("rl f_din_val", f_din_val, exp_val1 && (i == 1));
         if (exp_val1 && i == 1) chk("rl f_din", f_din, din1);
         if (we_e) begin
            chk("rl f_coe_addr", f_coe_addr, i - drain - 2);
            chk("rl f_coe_data", f_coe_data, i - drain - 1);
         end
         if (inject && i == 10) begin
            cfg_we   = 1'b1;
            cfg_addr = 6'd40;
            cfg_data = 16'hBAD0;
         end
      end
   endtask

   initial begin
      // Pacing: four back-to-back samples with s_valid held high.
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 30; j++)
            vecs.push_back('{1'b1, 1'b1, 16'(16'h40 * (k + 1)), j == 0, j == 0, 16'(16'h40 * (k + 1))});
      // One accept, then enable low for 100 cycles.
      for (int j = 0; j <= 100; j++)
         vecs.push_back('{j == 0, 1'b1, (j == 0) ? 16'h0140 : 16'hBEEF, j == 0, j == 0, 16'h0140});
      // Enable dropped mid-slot must not cut the countdown short.
      for (int j = 0; j < 30; j++)
         vecs.push_back('{!(j >= 1 && j <= 10), 1'b1, 16'h0180, j == 0, j == 0, 16'h0180});
      vecs.push_back('{1'b1, 1'b1, 16'h01C0, 1'b1, 1'b1, 16'h01C0});
      vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h01C0});

      rst_n    = 1'b0;
      enable   = 1'b1;
      s_data   = '0;
      s_valid  = 1'b0;
      cfg_we   = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;
      cfg_load = 1'b0;
      #23;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("first cycle s_ready", s_ready, 1);

      foreach (vecs[n]) begin
         @(negedge clk);
         enable  = vecs[n].en;
         s_valid = vecs[n].val;
         s_data  = vecs[n].data;
         #1;
         chk("tbl s_ready", s_ready, vecs[n].exp_rdy);
         @(posedge clk); #1;
         chk("tbl f_din_val", f_din_val, vecs[n].exp_fval);
         chk("tbl f_din",     f_din,     vecs[n].exp_din);
         chk("tbl cfg_busy",  cfg_busy,  0);
         chk("tbl cfg_err",   cfg_err,   0);
      end

      enable  = 1'b1;
      s_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         cfg_we   = 1'b1;
         cfg_addr = 6'(k);
         cfg_data = 16'(k + 1);
      end
      @(negedge clk);
      cfg_we = 1'b0;

      // Idle reload.
      @(negedge clk);
      cfg_load = 1'b1;
      reload_check(1, 1'b0, 1'b0, 16'h0);

      // Out-of-range write sets the sticky error.
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 6'd60;
      cfg_data = 16'hDEAD;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      chk("err oob", cfg_err, 1);

      // Reload clears the error; a write during LOAD sets it again and is dropped.
      @(negedge clk);
      cfg_load = 1'b1;
      reload_check(1, 1'b1, 1'b0, 16'h0);
      chk("err after load write", cfg_err, 1);

      // Next reload clears the error and shows the bank unchanged.
      @(negedge clk);
      cfg_load = 1'b1;
      reload_check(1, 1'b0, 1'b0, 16'h0);

      // Reload request in the same cycle as an accept.
      @(negedge clk);
      s_valid  = 1'b1;
      s_data   = 16'h5A5A;
      cfg_load = 1'b1;
      #1;
      chk("collision s_ready", s_ready, 1);
      reload_check(30, 1'b0, 1'b1, 16'h5A5A);

      // Reset asserted at LOAD write 20.
      @(negedge clk);
      cfg_load = 1'b1;
      for (int i = 1; i <= 23; i++) begin
         @(posedge clk); #1;
         if (i == 1) cfg_load = 1'b0;
      end
      chk("midload f_coe_we",   f_coe_we,   1);
      chk("midload f_coe_addr", f_coe_addr, 20);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midload reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post reset s_ready",  s_ready,  1);
      chk("post reset cfg_busy", cfg_busy, 0);
      @(posedge clk); #1;
      chk("post reset cfg_busy 2", cfg_busy, 0);
      chk("post reset f_coe_we",   f_coe_we, 0);
      chk("post reset s_ready 2",  s_ready,  1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
